// File: rtl/vga_timing_gen_pkg.sv
// Shared constants for the video timing generator: polarity levels, mode presets
// and the sync level helper used by both counter axes.
package vga_timing_gen_pkg;

   localparam logic POL_NEG = 1'b0;
   localparam logic POL_POS = 1'b1;

   // 640x480@60, 25.175 MHz nominal (25 MHz from 100 MHz / 4 is within monitor tolerance)
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;
   localparam logic VGA640_HS_POL = POL_NEG;
   localparam logic VGA640_VS_POL = POL_NEG;

   // 800x600@60, 40 MHz pixel clock
   localparam int SVGA800_H_ACTIVE = 800;
   localparam int SVGA800_H_FP     = 40;
   localparam int SVGA800_H_SYNC   = 128;
   localparam int SVGA800_H_BP     = 88;
   localparam int SVGA800_V_ACTIVE = 600;
   localparam int SVGA800_V_FP     = 1;
   localparam int SVGA800_V_SYNC   = 4;
   localparam int SVGA800_V_BP     = 23;
   localparam logic SVGA800_HS_POL = POL_POS;
   localparam logic SVGA800_VS_POL = POL_POS;

   function automatic logic sync_level(input logic asserted, input logic pol);
      return asserted ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One timing axis (horizontal or vertical): wrapping counter plus registered
// active/sync decode taken from the next count so all outputs change together.
module vga_timing_axis
   import vga_timing_gen_pkg::*;
#(
   parameter int   ACTIVE = 640,
   parameter int   FP     = 16,
   parameter int   SYNC   = 96,
   parameter int   BP     = 48,
   parameter logic POL    = 1'b0,
   parameter int   CW     = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          step,
   input  logic          restart,
   output logic [CW-1:0] cnt,
   output logic          active,
   output logic          sync,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST       = CW'(ACTIVE + FP + SYNC + BP - 1);
   localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE - 1);
   localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FP + SYNC - 1);

   logic [CW-1:0] cnt_nxt;
   logic          active_nxt;
   logic          sync_nxt;

   // wrap flags that the next step lands on 0; the other axis uses it as its carry
   assign wrap = (cnt == LAST);

   always_comb begin
      cnt_nxt = cnt;
      if (step) begin
         if (restart || wrap)
            cnt_nxt = '0;
         else
            cnt_nxt = cnt + CW'(1);
      end
      active_nxt = (cnt_nxt <= ACTIVE_END);
      sync_nxt   = sync_level((cnt_nxt >= SYNC_FIRST) && (cnt_nxt <= SYNC_LAST), POL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= LAST;
         active <= 1'b0;
         sync   <= sync_level(1'b0, POL);
      end else begin
         cnt    <= cnt_nxt;
         active <= active_nxt;
         sync   <= sync_nxt;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: pixel divider, H/V axes, line/frame strobes
// and frame counter. Define VGA_TIMING_GENLOCK_EN to add the frame_sync restart input.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int   H_ACTIVE = VGA640_H_ACTIVE,
   parameter int   H_FP     = VGA640_H_FP,
   parameter int   H_SYNC   = VGA640_H_SYNC,
   parameter int   H_BP     = VGA640_H_BP,
   parameter int   V_ACTIVE = VGA640_V_ACTIVE,
   parameter int   V_FP     = VGA640_V_FP,
   parameter int   V_SYNC   = VGA640_V_SYNC,
   parameter int   V_BP     = VGA640_V_BP,
   parameter logic HS_POL   = VGA640_HS_POL,
   parameter logic VS_POL   = VGA640_VS_POL,
   parameter int   PIX_DIV  = 4,
   parameter int   CW       = 11,
   parameter int   FCW      = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
`ifdef VGA_TIMING_GENLOCK_EN
   input  logic           frame_sync,
`endif
   output logic           Hsync,
   output logic           Vsync,
   output logic           pix_en,
   output logic           de,
   output logic [CW-1:0]  x,
   output logic [CW-1:0]  y,
   output logic           line_start,
   output logic           frame_start,
   output logic [FCW-1:0] frame_cnt
);

   localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

   logic [DW-1:0] div;
   logic          tick;
   logic          restart;
   logic          h_active, v_active;
   logic          h_wrap, v_wrap;
   logic          v_step;
   logic          line_evt, frame_evt;

   assign tick = en && (div == DIV_LAST);

   // dropping en clears the divider so a resume always waits a full pixel period
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div <= '0;
      else if (!en || tick)
         div <= '0;
      else
         div <= div + DW'(1);
   end

`ifdef VGA_TIMING_GENLOCK_EN
   logic sync_pend;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sync_pend <= 1'b0;
      else if (en)
         sync_pend <= frame_sync || (sync_pend && !tick);
   end

   assign restart = sync_pend;
`else
   assign restart = 1'b0;
`endif

   assign line_evt  = h_wrap || restart;
   assign frame_evt = (h_wrap && v_wrap) || restart;
   assign v_step    = tick && line_evt;

   vga_timing_axis #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL),
      .CW     (CW)
   ) u_h_axis (
      .clk     (clk),
      .reset   (reset),
      .step    (tick),
      .restart (restart),
      .cnt     (x),
      .active  (h_active),
      .sync    (Hsync),
      .wrap    (h_wrap)
   );

   vga_timing_axis #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL),
      .CW     (CW)
   ) u_v_axis (
      .clk     (clk),
      .reset   (reset),
      .step    (v_step),
      .restart (restart),
      .cnt     (y),
      .active  (v_active),
      .sync    (Vsync),
      .wrap    (v_wrap)
   );

   // both terms are flops updated on the same edge, so de carries no skew against x/y
   assign de = h_active && v_active;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_en      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         pix_en      <= tick;
         line_start  <= tick && line_evt;
         frame_start <= tick && frame_evt;
         if (tick && frame_evt)
            frame_cnt <= frame_cnt + FCW'(1);
      end
   end

endmodule
